// File: rtl/serial_word_rx_if.sv
// serial_word_rx_if: handshake/bus bundle for serial_word_rx.
//   master: bit-stream source plus word consumer (drives ENB, S_IN, DIR, READY, CLR_OVR)
//   slave : the receiver (drives DATA_OUT, VALID, LOCKED, OVERRUN, PAR_ERR)
// Signals:
//   ENB      bit strobe; S_IN sampled only when ENB=1
//   S_IN     serial data bit
//   DIR      bit order, 0 = MSB first, 1 = LSB first (latched at sync)
//   READY    consumer accepts DATA_OUT while VALID=1
//   CLR_OVR  clears the sticky OVERRUN flag
//   DATA_OUT received word
//   VALID    DATA_OUT holds an unaccepted word
//   LOCKED   receiver is collecting data words
//   OVERRUN  sticky, a completed word was dropped
//   PAR_ERR  one-cycle pulse on parity mismatch
interface serial_word_rx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             ENB;
    logic             S_IN;
    logic             DIR;
    logic             READY;
    logic             CLR_OVR;
    logic [WIDTH-1:0] DATA_OUT;
    logic             VALID;
    logic             LOCKED;
    logic             OVERRUN;
    logic             PAR_ERR;

    modport master (
        output ENB, S_IN, DIR, READY, CLR_OVR,
        input  DATA_OUT, VALID, LOCKED, OVERRUN, PAR_ERR
    );

    modport slave (
        input  ENB, S_IN, DIR, READY, CLR_OVR,
        output DATA_OUT, VALID, LOCKED, OVERRUN, PAR_ERR
    );
endinterface

// File: rtl/serial_word_rx.sv
// serial_word_rx: hunts for a sync pattern in a strobed serial bit stream, then
// assembles FRAME_WORDS words of WIDTH bits and presents each one on a
// single-entry valid/ready output register.
// Ports:
//   clk      single clock, rising edge
//   RESET_L  asynchronous active-low reset
//   bus      serial_word_rx_if.slave (see interface file for signal list)
// Optional feature: define RX_PARITY_EN to expect one even-parity bit after
// every word; failing words are dropped and flagged on PAR_ERR.
module serial_word_rx #(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       SYNC_W      = 4,
    parameter logic [SYNC_W-1:0] SYNC        = 4'b1011,
    parameter int unsigned       FRAME_WORDS = 2
) (
    input logic            clk,
    input logic            RESET_L,
    serial_word_rx_if.slave bus
);

`ifdef RX_PARITY_EN
    localparam int unsigned LastBit = WIDTH;      // parity strobe ends the word
`else
    localparam int unsigned LastBit = WIDTH - 1;
`endif
    localparam int unsigned BitCntW  = $clog2(WIDTH + 1);
    localparam int unsigned WordCntW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    typedef enum logic [0:0] {StHunt, StCollect} state_e;

    state_e                state_q, state_d;
    logic [SYNC_W-1:0]     win_q, win_d;
    logic [WIDTH-1:0]      asm_q, asm_d;
    logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WordCntW-1:0]   word_cnt_q, word_cnt_d;
    logic                  dir_q, dir_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q, ovr_d;

    logic [SYNC_W-1:0]     win_shift;
    logic [WIDTH-1:0]      asm_shift;
    logic [WIDTH-1:0]      word_val;
    logic                  word_ok;
    logic                  load;
    logic                  drop;
`ifdef RX_PARITY_EN
    logic                  par_fail;
    logic                  par_err_q;
`endif

    assign win_shift = {win_q[SYNC_W-2:0], bus.S_IN};
    assign asm_shift = dir_q ? {bus.S_IN, asm_q[WIDTH-1:1]} : {asm_q[WIDTH-2:0], bus.S_IN};

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        asm_d      = asm_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        dir_d      = dir_q;
        word_val   = asm_q;
        word_ok    = 1'b0;
`ifdef RX_PARITY_EN
        par_fail   = 1'b0;
`endif
        unique case (state_q)
            StHunt: begin
                if (bus.ENB) begin
                    win_d = win_shift;
                    if (win_shift == SYNC) begin
                        state_d    = StCollect;
                        dir_d      = bus.DIR;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                    end
                end
            end
            StCollect: begin
                if (bus.ENB) begin
                    if (bit_cnt_q == BitCntW'(LastBit)) begin
                        bit_cnt_d = '0;
`ifdef RX_PARITY_EN
                        // Data is already complete in asm_q; this strobe is parity.
                        word_val = asm_q;
                        word_ok  = ~^{asm_q, bus.S_IN};
                        par_fail = ^{asm_q, bus.S_IN};
`else
                        asm_d    = asm_shift;
                        word_val = asm_shift;
                        word_ok  = 1'b1;
`endif
                        if (word_cnt_q == WordCntW'(FRAME_WORDS - 1)) begin
                            state_d    = StHunt;
                            win_d      = '0;  // sync never spans data bits
                            word_cnt_d = '0;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end else begin
                        asm_d     = asm_shift;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Output register: a completing word may load on the same edge the old one is accepted.
    always_comb begin
        load    = word_ok && (!valid_q || bus.READY);
        drop    = word_ok && valid_q && !bus.READY;
        data_d  = load ? word_val : data_q;
        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && bus.READY) begin
            valid_d = 1'b0;
        end
        ovr_d = ovr_q;
        if (drop) begin
            ovr_d = 1'b1;
        end else if (bus.CLR_OVR) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q    <= StHunt;
            win_q      <= '0;
            asm_q      <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            dir_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            asm_q      <= asm_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            dir_q      <= dir_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_fail;
        end
    end
    assign bus.PAR_ERR = par_err_q;
`else
    assign bus.PAR_ERR = 1'b0;
`endif

    assign bus.DATA_OUT = data_q;
    assign bus.VALID    = valid_q;
    assign bus.LOCKED   = (state_q == StCollect);
    assign bus.OVERRUN  = ovr_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: directed self-checking bench for serial_word_rx
// (WIDTH=8, SYNC=1011, FRAME_WORDS=2). Inputs change 1 time unit after the
// rising edge and outputs are sampled there too.
module tb_serial_word_rx;

    logic clk = 1'b0;
    logic RESET_L;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_word_rx_if #(.WIDTH(8)) bus ();

    serial_word_rx #(
        .WIDTH       (8),
        .SYNC_W      (4),
        .SYNC        (4'b1011),
        .FRAME_WORDS (2)
    ) dut (
        .clk     (clk),
        .RESET_L (RESET_L),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic enb, input logic b);
        bus.ENB  = enb;
        bus.S_IN = b;
        @(posedge clk);
        #1;
        bus.ENB  = 1'b0;
    endtask

    task automatic send_sync(input logic lsb);
        bus.DIR = lsb;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
    endtask

    // Sends one word (plus parity when enabled). DIR is flipped mid-word to show
    // it is ignored while locked. READY takes rdy_last before the final strobe.
    task automatic send_word(input logic [7:0] w, input logic lsb, input bit gap,
                             input logic rdy_last);
        logic b;
        for (int i = 0; i < 8; i++) begin
            b = lsb ? w[i] : w[7-i];
            if (i == 4) bus.DIR = ~bus.DIR;
`ifndef RX_PARITY_EN
            if (i == 7) bus.READY = rdy_last;
`endif
            step(1'b1, b);
`ifdef RX_PARITY_EN
            if (gap) step(1'b0, 1'b0);
`else
            if (gap && i < 7) step(1'b0, 1'b0);
`endif
        end
`ifdef RX_PARITY_EN
        bus.READY = rdy_last;
        step(1'b1, ^w);
`endif
    endtask

    initial begin
        RESET_L     = 1'b0;
        bus.ENB     = 1'b0;
        bus.S_IN    = 1'b0;
        bus.DIR     = 1'b0;
        bus.READY   = 1'b1;
        bus.CLR_OVR = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data",    bus.DATA_OUT, 8'h00);
        chk("rst_valid",   bus.VALID,    1'b0);
        chk("rst_locked",  bus.LOCKED,   1'b0);
        chk("rst_overrun", bus.OVERRUN,  1'b0);
        chk("rst_parerr",  bus.PAR_ERR,  1'b0);
        RESET_L = 1'b1;
        step(1'b0, 1'b0);

        // Reset mid-word
        send_sync(1'b0);
        chk("mid_lock", bus.LOCKED, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        RESET_L = 1'b0;
        #1;
        chk("mid_rst_locked", bus.LOCKED,   1'b0);
        chk("mid_rst_valid",  bus.VALID,    1'b0);
        chk("mid_rst_data",   bus.DATA_OUT, 8'h00);
        @(posedge clk);
        #1;
        RESET_L = 1'b1;
        send_sync(1'b0);
        send_word(8'h3C, 1'b0, 1'b0, 1'b1);
        chk("mid_fresh_data",  bus.DATA_OUT, 8'h3C);
        chk("mid_fresh_valid", bus.VALID,    1'b1);
        send_word(8'h5A, 1'b0, 1'b0, 1'b1);
        chk("mid_w2_data",   bus.DATA_OUT, 8'h5A);
        chk("mid_w2_locked", bus.LOCKED,   1'b0);
        step(1'b0, 1'b0);
        chk("mid_accept", bus.VALID, 1'b0);

        // MSB-first frame, READY high
        send_sync(1'b0);
        chk("msb_lock", bus.LOCKED, 1'b1);
        send_word(8'h3C, 1'b0, 1'b0, 1'b1);
        chk("msb_w1_data",   bus.DATA_OUT, 8'h3C);
        chk("msb_w1_valid",  bus.VALID,    1'b1);
        chk("msb_w1_locked", bus.LOCKED,   1'b1);
        send_word(8'hA5, 1'b0, 1'b0, 1'b1);
        chk("msb_w2_data",   bus.DATA_OUT, 8'hA5);
        chk("msb_w2_valid",  bus.VALID,    1'b1);
        chk("msb_w2_locked", bus.LOCKED,   1'b0);
        step(1'b0, 1'b0);
        chk("msb_accept", bus.VALID, 1'b0);

        // LSB-first with ENB gaps
        send_sync(1'b1);
        send_word(8'h3C, 1'b1, 1'b1, 1'b1);
        chk("lsb_data",   bus.DATA_OUT, 8'h3C);
        chk("lsb_valid",  bus.VALID,    1'b1);
        chk("lsb_locked", bus.LOCKED,   1'b1);
        send_word(8'h96, 1'b1, 1'b1, 1'b1);
        chk("lsb_w2_data",   bus.DATA_OUT, 8'h96);
        chk("lsb_w2_locked", bus.LOCKED,   1'b0);
        step(1'b0, 1'b0);

        // Overrun with READY low
        bus.READY = 1'b0;
        send_sync(1'b0);
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        chk("ovr_w1_data", bus.DATA_OUT, 8'h11);
        chk("ovr_w1_ovr",  bus.OVERRUN,  1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b0);
        chk("ovr_data",   bus.DATA_OUT, 8'h11);
        chk("ovr_valid",  bus.VALID,    1'b1);
        chk("ovr_set",    bus.OVERRUN,  1'b1);
        chk("ovr_locked", bus.LOCKED,   1'b0);
        bus.CLR_OVR = 1'b1;
        step(1'b0, 1'b0);
        bus.CLR_OVR = 1'b0;
        chk("ovr_clr",       bus.OVERRUN, 1'b0);
        chk("ovr_clr_valid", bus.VALID,   1'b1);

        // Simultaneous accept and load
        bus.READY = 1'b1;
        step(1'b0, 1'b0);
        chk("sim_drain", bus.VALID, 1'b0);
        bus.READY = 1'b0;
        send_sync(1'b0);
        send_word(8'h44, 1'b0, 1'b0, 1'b0);
        chk("sim_w1_data", bus.DATA_OUT, 8'h44);
        send_word(8'h66, 1'b0, 1'b0, 1'b1);
        chk("sim_data",  bus.DATA_OUT, 8'h66);
        chk("sim_valid", bus.VALID,    1'b1);
        chk("sim_ovr",   bus.OVERRUN,  1'b0);
        step(1'b0, 1'b0);
        chk("sim_accept", bus.VALID, 1'b0);

`ifdef RX_PARITY_EN
        // Good parity word then a bad one
        send_sync(1'b0);
        send_word(8'h3C, 1'b0, 1'b0, 1'b1);
        chk("par_w1_data", bus.DATA_OUT, 8'h3C);
        chk("par_w1_err",  bus.PAR_ERR,  1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 7) ? 1'b1 : 1'b0);
        end
        step(1'b1, 1'b0);
        chk("par_err",    bus.PAR_ERR,  1'b1);
        chk("par_data",   bus.DATA_OUT, 8'h3C);
        chk("par_valid",  bus.VALID,    1'b0);
        chk("par_ovr",    bus.OVERRUN,  1'b0);
        chk("par_locked", bus.LOCKED,   1'b0);
        step(1'b0, 1'b0);
        chk("par_pulse", bus.PAR_ERR, 1'b0);
`else
        chk("nopar_err", bus.PAR_ERR, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
